// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one external memory port between instruction fetch and data access.
// Data normally wins arbitration. A streak counter lets fetch in after
// MAX_D_STREAK back-to-back data grants taken while fetch was waiting.
// A grant that sees no bus completion within TIMEOUT cycles is aborted. The
// abort returns a NOP to fetch, or zero to data, and raises a one-cycle bus_err.
//
// state | meaning
// IDLE  | bus free, arbitrate on current i_req/d_req
// GNT_I | fetch owns the bus, b_* hold the latched fetch request
// GNT_D | data owns the bus, b_* hold the latched data request
// TURN  | one dead bus cycle after completion or abort (abort cycle carries bus_err)

module mem_bus_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready_n,
    output logic        i_busy,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready_n,
    output logic        d_busy,
    output logic        b_req,
    output logic        b_write,
    output logic [1:0]  b_size,
    output logic [31:0] b_addr,
    output logic [31:0] b_wdata,
    input  logic [31:0] b_rdata,
    input  logic        b_ready_n,
    output logic        bus_err,
    output logic [1:0]  grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10,
        TURN  = 2'b11
    } state_t;

    localparam logic [3:0]  STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [9:0]  TMO_LAST   = 10'(TIMEOUT - 1);
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    state_t      state;
    logic [3:0]  streak;
    logic [9:0]  tmo_cnt;
    logic        err_fetch;

    logic        at_max;
    logic        data_win;
    logic        fetch_win;
    logic        i_done;
    logic        d_done;
    logic        i_abort;
    logic        d_abort;

    // Arbitration and completion decode
    always_comb begin
        at_max    = (streak == STREAK_MAX);
        data_win  = d_req & ~(i_req & at_max);
        fetch_win = i_req & ~data_win;
        i_done    = (state == GNT_I) & ~b_ready_n;
        d_done    = (state == GNT_D) & ~b_ready_n;
        i_abort   = bus_err & err_fetch;
        d_abort   = bus_err & ~err_fetch;
    end

    // Requester-side handshake: completion data passes straight through from the bus
    always_comb begin
        i_ready_n = ~(i_done | i_abort);
        d_ready_n = ~(d_done | d_abort);
        i_rdata   = i_done ? b_rdata : (i_abort ? NOP_INSN : 32'h0);
        d_rdata   = d_done ? b_rdata : 32'h0;
        i_busy    = i_req & (state != GNT_I);
        d_busy    = d_req & (state != GNT_D);
    end

    // Arbiter FSM with registered bus-side outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            streak    <= '0;
            tmo_cnt   <= '0;
            err_fetch <= 1'b0;
            b_req     <= 1'b0;
            b_write   <= 1'b0;
            b_size    <= 2'b00;
            b_addr    <= 32'h0;
            b_wdata   <= 32'h0;
            bus_err   <= 1'b0;
            grant_id  <= 2'b00;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (data_win) begin
                        state    <= GNT_D;
                        b_req    <= 1'b1;
                        b_write  <= d_write;
                        b_size   <= d_size;
                        b_addr   <= d_addr;
                        b_wdata  <= d_wdata;
                        grant_id <= 2'b10;
                        if (!i_req) begin
                            streak <= '0;
                        end else if (!at_max) begin
                            streak <= streak + 4'd1;
                        end
                    end else if (fetch_win) begin
                        state    <= GNT_I;
                        b_req    <= 1'b1;
                        b_write  <= 1'b0;
                        b_size   <= 2'b10;
                        b_addr   <= i_addr;
                        b_wdata  <= 32'h0;
                        grant_id <= 2'b01;
                        streak   <= '0;
                    end else begin
                        streak <= '0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (!b_ready_n) begin
                        state    <= TURN;
                        b_req    <= 1'b0;
                        grant_id <= 2'b00;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state     <= TURN;
                        b_req     <= 1'b0;
                        grant_id  <= 2'b00;
                        bus_err   <= 1'b1;
                        err_fetch <= (state == GNT_I);
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    b_req    <= 1'b0;
                    grant_id <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: reset checks, a table of single-request
// vectors, directed multi-cycle sequences and a randomized run against a
// transaction-level reference model.

module tb_mem_bus_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready_n;
    logic        i_busy;
    logic        d_req;
    logic        d_write;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready_n;
    logic        d_busy;
    logic        b_req;
    logic        b_write;
    logic [1:0]  b_size;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [31:0] b_rdata;
    logic        b_ready_n;
    logic        bus_err;
    logic [1:0]  grant_id;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready_n(i_ready_n), .i_busy(i_busy),
        .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready_n(d_ready_n), .d_busy(d_busy),
        .b_req(b_req), .b_write(b_write), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ready_n(b_ready_n), .bus_err(bus_err), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_write = 1'b0; d_size = 2'b00; d_addr = 32'h0; d_wdata = 32'h0;
        b_rdata = 32'h0; b_ready_n = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic        iq;
        logic        dq;
        logic        dw;
        logic [1:0]  ds;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [1:0]  gid;
        logic        bw;
        logic [1:0]  bs;
        logic [31:0] ba;
        logic        ib;
        logic        db;
    } vec_t;

    vec_t vecs[5];

    // ---------------- reference model ----------------
    int          m_owner;
    int          m_age;
    int          m_rest;
    int          m_streak;
    bit          m_err;
    int          m_err_who;
    logic        m_bw;
    logic [1:0]  m_bs;
    logic [31:0] m_ba;
    logic [31:0] m_bwd;
    bit          f_done;
    bit          dd_done;

    task automatic model_init();
        m_owner = 0; m_age = 0; m_rest = 0; m_streak = 0; m_err = 0; m_err_who = 0;
        m_bw = 0; m_bs = 0; m_ba = 0; m_bwd = 0; f_done = 0; dd_done = 0;
    endtask

    // One clock edge of the model, using the inputs that were present at that edge
    task automatic model_advance();
        m_err = 0;
        if (m_owner != 0) begin
            if (!b_ready_n) begin
                m_owner = 0;
                m_rest  = 1;
            end else begin
                m_age++;
                if (m_age == TMO) begin
                    m_err     = 1;
                    m_err_who = m_owner;
                    m_owner   = 0;
                    m_rest    = 1;
                end
            end
        end else if (m_rest > 0) begin
            m_rest--;
        end else if (d_req && !(i_req && m_streak == MAXS)) begin
            m_owner  = 2;
            m_age    = 0;
            m_streak = i_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            m_bw = d_write; m_bs = d_size; m_ba = d_addr; m_bwd = d_wdata;
        end else if (i_req) begin
            m_owner  = 1;
            m_age    = 0;
            m_streak = 0;
            m_bw = 1'b0; m_bs = 2'b10; m_ba = i_addr;
        end else begin
            m_streak = 0;
        end
    endtask

    task automatic model_check();
        bit done;
        bit e_i;
        bit e_d;
        done = (m_owner != 0) && !b_ready_n;
        e_i  = (done && m_owner == 1) || (m_err && m_err_who == 1);
        e_d  = (done && m_owner == 2) || (m_err && m_err_who == 2);
        chk("rnd_b_req", 32'(b_req), 32'(m_owner != 0));
        chk("rnd_grant_id", 32'(grant_id), 32'(m_owner));
        if (m_owner != 0) begin
            chk("rnd_b_write", 32'(b_write), 32'(m_bw));
            chk("rnd_b_size", 32'(b_size), 32'(m_bs));
            chk("rnd_b_addr", b_addr, m_ba);
            if (m_owner == 2) chk("rnd_b_wdata", b_wdata, m_bwd);
        end
        chk("rnd_bus_err", 32'(bus_err), 32'(m_err));
        chk("rnd_i_ready_n", 32'(i_ready_n), 32'(!e_i));
        chk("rnd_d_ready_n", 32'(d_ready_n), 32'(!e_d));
        if (e_i) chk("rnd_i_rdata", i_rdata, done ? b_rdata : 32'h0000_0013);
        if (e_d) chk("rnd_d_rdata", d_rdata, done ? b_rdata : 32'h0);
        chk("rnd_i_busy", 32'(i_busy), 32'(i_req && m_owner != 1));
        chk("rnd_d_busy", 32'(d_busy), 32'(d_req && m_owner != 2));
        f_done  = e_i;
        dd_done = e_d;
    endtask

    initial begin
        int          cnt;
        int          ng;
        int          gcyc[6];
        logic [1:0]  gseq[6];
        logic [1:0]  gexp[6];
        logic [31:0] rd;

        // ---------------- reset state ----------------
        rst = 1'b0;
        idle_inputs();
        #12;
        chk("rst_b_req", 32'(b_req), 32'h0);
        chk("rst_b_write", 32'(b_write), 32'h0);
        chk("rst_b_size", 32'(b_size), 32'h0);
        chk("rst_b_addr", b_addr, 32'h0);
        chk("rst_b_wdata", b_wdata, 32'h0);
        chk("rst_i_ready_n", 32'(i_ready_n), 32'h1);
        chk("rst_d_ready_n", 32'(d_ready_n), 32'h1);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_busy", {30'h0, i_busy, d_busy}, 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);

        // ---------------- table-driven single requests ----------------
        vecs[0] = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h100, 32'h0,    32'h0,         2'b01, 1'b0, 2'b10, 32'h100,  1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 2'b10, 32'h0,   32'h2000, 32'h0,         2'b10, 1'b0, 2'b10, 32'h2000, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 2'b01, 32'h400, 32'h2000, 32'hCAFE_F00D, 2'b10, 1'b1, 2'b01, 32'h2000, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 2'b00, 32'h0,   32'h3,    32'h0000_00AB, 2'b10, 1'b1, 2'b00, 32'h3,    1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h44,  32'h88,   32'h0,         2'b00, 1'b0, 2'b00, 32'h0,    1'b0, 1'b0};

        for (int k = 0; k < 5; k++) begin
            do_reset();
            i_req = vecs[k].iq; i_addr = vecs[k].ia;
            d_req = vecs[k].dq; d_write = vecs[k].dw; d_size = vecs[k].ds;
            d_addr = vecs[k].da; d_wdata = vecs[k].dwd;
            @(negedge clk); #1;
            chk("vec_grant_id", 32'(grant_id), 32'(vecs[k].gid));
            chk("vec_b_req", 32'(b_req), 32'(vecs[k].gid != 2'b00));
            if (vecs[k].gid != 2'b00) begin
                chk("vec_b_write", 32'(b_write), 32'(vecs[k].bw));
                chk("vec_b_size", 32'(b_size), 32'(vecs[k].bs));
                chk("vec_b_addr", b_addr, vecs[k].ba);
            end
            if (vecs[k].gid == 2'b10) chk("vec_b_wdata", b_wdata, vecs[k].dwd);
            chk("vec_i_busy", 32'(i_busy), 32'(vecs[k].ib));
            chk("vec_d_busy", 32'(d_busy), 32'(vecs[k].db));
            rd = $urandom();
            b_rdata = rd; b_ready_n = 1'b0;
            #1;
            chk("vec_i_ready_n", 32'(i_ready_n), 32'(vecs[k].gid != 2'b01));
            chk("vec_d_ready_n", 32'(d_ready_n), 32'(vecs[k].gid != 2'b10));
            if (vecs[k].gid == 2'b01) chk("vec_i_rdata", i_rdata, rd);
            if (vecs[k].gid == 2'b10) chk("vec_d_rdata", d_rdata, rd);
            @(negedge clk);
            idle_inputs();
            #1;
            chk("vec_turn_grant", 32'(grant_id), 32'h0);
            chk("vec_turn_b_req", 32'(b_req), 32'h0);
        end

        // ---------------- reset in the middle of a data grant ----------------
        do_reset();
        d_req = 1'b1; d_addr = 32'h40;
        @(negedge clk); #1;
        chk("t1_b_req_on", 32'(b_req), 32'h1);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk("t1_async_b_req", 32'(b_req), 32'h0);
        chk("t1_async_grant", 32'(grant_id), 32'h0);
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        b_ready_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("t1_post_grant", 32'(grant_id), 32'h0);
            chk("t1_post_d_ready_n", 32'(d_ready_n), 32'h1);
            chk("t1_post_i_ready_n", 32'(i_ready_n), 32'h1);
        end

        // ---------------- fetch read, completion two cycles after b_req ----------------
        do_reset();
        i_req = 1'b1; i_addr = 32'h100;
        @(negedge clk); #1;
        chk("t2_b_req", 32'(b_req), 32'h1);
        chk("t2_b_addr", b_addr, 32'h100);
        chk("t2_b_size", 32'(b_size), 32'h2);
        @(negedge clk); #1;
        chk("t2_wait_i_ready_n", 32'(i_ready_n), 32'h1);
        @(negedge clk);
        b_ready_n = 1'b0; b_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t2_i_ready_n", 32'(i_ready_n), 32'h0);
        chk("t2_i_rdata", i_rdata, 32'hDEAD_BEEF);
        chk("t2_d_ready_n", 32'(d_ready_n), 32'h1);
        @(negedge clk);
        i_req = 1'b0; b_ready_n = 1'b1;
        #1;
        chk("t2_turn_i_ready_n", 32'(i_ready_n), 32'h1);
        chk("t2_turn_b_req", 32'(b_req), 32'h0);
        @(negedge clk); #1;
        chk("t2_idle_grant", 32'(grant_id), 32'h0);

        // ---------------- simultaneous requests: data first, then fetch ----------------
        do_reset();
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_write = 1'b1; d_addr = 32'h2000; d_size = 2'b01; d_wdata = 32'h1234_5678;
        @(negedge clk); #1;
        chk("t3_grant_d", 32'(grant_id), 32'h2);
        chk("t3_b_write", 32'(b_write), 32'h1);
        chk("t3_b_size", 32'(b_size), 32'h1);
        chk("t3_i_busy_a", 32'(i_busy), 32'h1);
        @(negedge clk);
        b_ready_n = 1'b0;
        #1;
        chk("t3_d_ready_n", 32'(d_ready_n), 32'h0);
        chk("t3_i_ready_n", 32'(i_ready_n), 32'h1);
        chk("t3_i_busy_b", 32'(i_busy), 32'h1);
        @(negedge clk);
        d_req = 1'b0; b_ready_n = 1'b1;
        #1;
        chk("t3_turn", 32'(grant_id), 32'h0);
        @(negedge clk); #1;
        chk("t3_idle", 32'(grant_id), 32'h0);
        @(negedge clk); #1;
        chk("t3_grant_i", 32'(grant_id), 32'h1);
        chk("t3_fetch_addr", b_addr, 32'h100);
        chk("t3_fetch_write", 32'(b_write), 32'h0);
        chk("t3_i_busy_c", 32'(i_busy), 32'h0);

        // ---------------- data streak fairness ----------------
        do_reset();
        i_req = 1'b1; i_addr = 32'h500;
        d_req = 1'b1; d_addr = 32'h600; d_size = 2'b10;
        b_ready_n = 1'b0;
        ng = 0;
        for (int c = 0; c < 6; c++) begin
            gseq[c] = 2'b00;
            gcyc[c] = 0;
        end
        gexp[0] = 2'b10; gexp[1] = 2'b10; gexp[2] = 2'b10;
        gexp[3] = 2'b10; gexp[4] = 2'b01; gexp[5] = 2'b10;
        for (int c = 1; c <= 40 && ng < 6; c++) begin
            @(negedge clk); #1;
            if (grant_id != 2'b00) begin
                gseq[ng] = grant_id;
                gcyc[ng] = c;
                ng++;
            end
        end
        chk("t4_grants_seen", 32'(ng), 32'd6);
        for (int k = 0; k < 6; k++) chk("t4_grant_order", 32'(gseq[k]), 32'(gexp[k]));
        chk("t4_spacing", 32'(gcyc[1] - gcyc[0]), 32'd3);

        // ---------------- fetch timeout ----------------
        do_reset();
        i_req = 1'b1; i_addr = 32'h700;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (b_req) cnt++;
            else if (cnt > 0) break;
        end
        chk("t5_b_req_cycles", 32'(cnt), 32'd8);
        chk("t5_bus_err", 32'(bus_err), 32'h1);
        chk("t5_i_ready_n", 32'(i_ready_n), 32'h0);
        chk("t5_i_rdata_nop", i_rdata, 32'h0000_0013);
        chk("t5_d_ready_n", 32'(d_ready_n), 32'h1);
        i_req = 1'b0;
        @(negedge clk); #1;
        chk("t5_bus_err_clear", 32'(bus_err), 32'h0);
        chk("t5_i_ready_n_clear", 32'(i_ready_n), 32'h1);

        // ---------------- completion on the timeout cycle ----------------
        do_reset();
        i_req = 1'b1; i_addr = 32'h800;
        repeat (7) @(negedge clk);
        @(negedge clk);
        b_ready_n = 1'b0; b_rdata = 32'h0BAD_CAFE;
        #1;
        chk("t6_b_req", 32'(b_req), 32'h1);
        chk("t6_i_ready_n", 32'(i_ready_n), 32'h0);
        chk("t6_i_rdata", i_rdata, 32'h0BAD_CAFE);
        chk("t6_bus_err_a", 32'(bus_err), 32'h0);
        @(negedge clk);
        i_req = 1'b0; b_ready_n = 1'b1;
        #1;
        chk("t6_bus_err_b", 32'(bus_err), 32'h0);
        chk("t6_i_ready_n_b", 32'(i_ready_n), 32'h1);

        // ---------------- randomized run against the reference model ----------------
        do_reset();
        model_init();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            model_advance();
            if (i_req && f_done) begin
                i_req  = ($urandom_range(0, 1) == 1);
                i_addr = $urandom() & 32'hFFFF_FFFC;
            end else if (!i_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    i_req  = 1'b1;
                    i_addr = $urandom() & 32'hFFFF_FFFC;
                end
            end else if (m_owner == 1 && $urandom_range(0, 15) == 0) begin
                i_req = 1'b0;
            end
            if (d_req && dd_done) begin
                d_req = ($urandom_range(0, 1) == 1);
            end else if (!d_req) begin
                d_req = ($urandom_range(0, 2) == 0);
            end else if (m_owner == 2 && $urandom_range(0, 15) == 0) begin
                d_req = 1'b0;
            end
            if (dd_done || !d_req) begin
                d_write = 1'($urandom_range(0, 1));
                d_size  = 2'($urandom_range(0, 2));
                d_addr  = $urandom();
                d_wdata = $urandom();
            end
            b_rdata   = $urandom();
            b_ready_n = ($urandom_range(0, 3) != 0);
            #1;
            model_check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
